// File: rtl/btn_pulse_cond_c_pkg.sv
// Shared definitions for the push-button conditioner: repeat FSM encoding and
// timing constants for the 50 MHz board build and the reduced simulation build.
package btn_pulse_cond_c_pkg;

  typedef enum logic [1:0] {
    RPT_IDLE = 2'd0,
    RPT_HOLD = 2'd1,
    RPT_RPT  = 2'd2
  } rpt_state_t;

  localparam int BOARD_DB_CYCLES     = 1000000;
  localparam int BOARD_REPEAT_DELAY  = 50000000;
  localparam int BOARD_REPEAT_PERIOD = 10000000;

  localparam int SIM_DB_CYCLES       = 4;
  localparam int SIM_REPEAT_DELAY    = 20;
  localparam int SIM_REPEAT_PERIOD   = 8;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_cell_c.sv
// One button channel: 2-flop synchroniser followed by a counter debouncer.
// Outputs the debounced stable level and a one-clock strobe on its 0->1 change.
module debounce_cell_c
  import btn_pulse_cond_c_pkg::*;
#(
  parameter int DB_CYCLES = BOARD_DB_CYCLES
) (
  input  logic clk_c,
  input  logic reset_c,
  input  logic raw_c,
  output logic stable_c,
  output logic rise_c
);

  localparam int             CW     = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0]  C_LAST = CW'(DB_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic          r_rise;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk_c or posedge reset_c) begin
    if (reset_c) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_rise   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      // NOTE: non-blocking so each flop takes its pre-edge input; blocking would
      // collapse the two synchroniser stages into a single wire.
      r_sync1 <= raw_c;
      r_sync2 <= r_sync1;
      r_rise  <= 1'b0;
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == C_LAST) begin
        r_stable <= ~r_stable;
        r_rise   <= ~r_stable;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign stable_c = r_stable;
  assign rise_c   = r_rise;

endmodule

// File: rtl/btn_pulse_cond_c.sv
// Push-button conditioner feeding the 0..10 up/down counter: debounced enable level
// plus one-clock up/down count pulses with optional auto-repeat and conflict lockout.
module btn_pulse_cond_c
  import btn_pulse_cond_c_pkg::*;
#(
  parameter int DB_CYCLES     = BOARD_DB_CYCLES,
  parameter bit REPEAT_EN     = 1'b1,
  parameter int REPEAT_DELAY  = BOARD_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = BOARD_REPEAT_PERIOD
) (
  input  logic clk_c,
  input  logic reset_c,
  input  logic up_raw_c,
  input  logic down_raw_c,
  input  logic en_raw_c,
  output logic up_p_c,
  output logic down_p_c,
  output logic enable_c
);

  localparam int                RPT_W       = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic [RPT_W-1:0]  DELAY_LOAD  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0]  PERIOD_LOAD = RPT_W'(REPEAT_PERIOD - 1);

  // Index 0 is the up direction, index 1 the down direction.
  logic [1:0]       w_s;
  logic [1:0]       w_rise;
  logic [1:0]       w_fire;
  logic             w_conflict;
  logic             w_en_s;
  logic             w_en_rise_unused;
  rpt_state_t       r_state     [2];
  rpt_state_t       w_state_nxt [2];
  logic [RPT_W-1:0] r_rcnt      [2];
  logic [RPT_W-1:0] w_rcnt_nxt  [2];
  logic             r_up_p;
  logic             r_dn_p;

  debounce_cell_c #(.DB_CYCLES(DB_CYCLES)) u_db_up (
    .clk_c    (clk_c),
    .reset_c  (reset_c),
    .raw_c    (up_raw_c),
    .stable_c (w_s[0]),
    .rise_c   (w_rise[0])
  );

  debounce_cell_c #(.DB_CYCLES(DB_CYCLES)) u_db_down (
    .clk_c    (clk_c),
    .reset_c  (reset_c),
    .raw_c    (down_raw_c),
    .stable_c (w_s[1]),
    .rise_c   (w_rise[1])
  );

  debounce_cell_c #(.DB_CYCLES(DB_CYCLES)) u_db_en (
    .clk_c    (clk_c),
    .reset_c  (reset_c),
    .raw_c    (en_raw_c),
    .stable_c (w_en_s),
    .rise_c   (w_en_rise_unused)
  );

  // Both buttons held is ambiguous: kill all pulses and park both FSMs until a
  // fresh press arrives after one of them is released.
  assign w_conflict = w_s[0] & w_s[1];

  always_comb begin
    // NOTE: every output gets a default before any branch; a path that skips an
    // assignment would otherwise infer a latch.
    w_fire      = '0;
    w_state_nxt = r_state;
    w_rcnt_nxt  = r_rcnt;
    for (int i = 0; i < 2; i++) begin
      if (w_conflict || !w_s[i]) begin
        w_state_nxt[i] = RPT_IDLE;
        w_rcnt_nxt[i]  = '0;
      end else if (w_rise[i]) begin
        w_fire[i] = 1'b1;
        if (REPEAT_EN) begin
          w_state_nxt[i] = RPT_HOLD;
          w_rcnt_nxt[i]  = DELAY_LOAD;
        end
      end else if (r_state[i] != RPT_IDLE) begin
        if (r_rcnt[i] == '0) begin
          w_fire[i]      = 1'b1;
          w_state_nxt[i] = RPT_RPT;
          w_rcnt_nxt[i]  = PERIOD_LOAD;
        end else begin
          w_rcnt_nxt[i] = r_rcnt[i] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_c or posedge reset_c) begin
    if (reset_c) begin
      r_state <= '{RPT_IDLE, RPT_IDLE};
      r_rcnt  <= '{default: '0};
      r_up_p  <= 1'b0;
      r_dn_p  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rcnt  <= w_rcnt_nxt;
      r_up_p  <= w_fire[0];
      r_dn_p  <= w_fire[1];
    end
  end

  assign up_p_c   = r_up_p;
  assign down_p_c = r_dn_p;
  assign enable_c = w_en_s;

endmodule

// File: tb/tb_btn_pulse_cond_c.sv
// Bench for btn_pulse_cond_c: two instances (auto-repeat on and off) driven by the
// same buttons, checked every clock against a schedule-based model and literal timings.
module tb_btn_pulse_cond_c;
  import btn_pulse_cond_c_pkg::*;

  localparam int DB = SIM_DB_CYCLES;
  localparam int D  = SIM_REPEAT_DELAY;
  localparam int P  = SIM_REPEAT_PERIOD;

  logic clk_c      = 1'b0;
  logic reset_c    = 1'b0;
  logic up_raw_c   = 1'b0;
  logic down_raw_c = 1'b0;
  logic en_raw_c   = 1'b0;
  logic up_p_c, down_p_c, enable_c;
  logic up_p_n, down_p_n, enable_n;

  int checks = 0;
  int errors = 0;
  int ncyc   = 0;
  int up_log[$], dn_log[$], up_log_n[$], dn_log_n[$];
  int rpt_offs[6];

  // Model: raw samples of the last two edges, debounced levels now and one edge
  // earlier, mismatch run lengths, and the press edge of each active repeat.
  logic [2:0] m_pipe1, m_pipe2, m_s, m_s_old;
  int         m_run[3];
  logic [1:0] m_act;
  int         m_press[2];
  logic [1:0] m_p, m_pn;

  btn_pulse_cond_c #(
    .DB_CYCLES(DB), .REPEAT_EN(1'b1), .REPEAT_DELAY(D), .REPEAT_PERIOD(P)
  ) dut (
    .clk_c(clk_c), .reset_c(reset_c), .up_raw_c(up_raw_c), .down_raw_c(down_raw_c),
    .en_raw_c(en_raw_c), .up_p_c(up_p_c), .down_p_c(down_p_c), .enable_c(enable_c)
  );

  btn_pulse_cond_c #(
    .DB_CYCLES(DB), .REPEAT_EN(1'b0), .REPEAT_DELAY(D), .REPEAT_PERIOD(P)
  ) dut_n (
    .clk_c(clk_c), .reset_c(reset_c), .up_raw_c(up_raw_c), .down_raw_c(down_raw_c),
    .en_raw_c(en_raw_c), .up_p_c(up_p_n), .down_p_c(down_p_n), .enable_c(enable_n)
  );

  always #5 clk_c = ~clk_c;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pipe1 = '0; m_pipe2 = '0; m_s = '0; m_s_old = '0;
    m_act = '0; m_p = '0; m_pn = '0;
    for (int i = 0; i < 3; i++) m_run[i] = 0;
    for (int d = 0; d < 2; d++) m_press[d] = 0;
  endtask

  task automatic model_step(input logic [2:0] raw, input int n);
    logic [2:0] s_prev;
    int k;
    for (int d = 0; d < 2; d++) begin
      m_p[d]  = 1'b0;
      m_pn[d] = 1'b0;
      if ((m_s[0] && m_s[1]) || !m_s[d]) begin
        m_act[d] = 1'b0;
      end else if (!m_s_old[d]) begin
        m_p[d] = 1'b1; m_pn[d] = 1'b1; m_act[d] = 1'b1; m_press[d] = n;
      end else if (m_act[d]) begin
        k = n - m_press[d];
        if (k >= D && (k - D) % P == 0) m_p[d] = 1'b1;
      end
    end
    s_prev = m_s;
    for (int i = 0; i < 3; i++) begin
      if (m_pipe2[i] != m_s[i]) begin
        m_run[i]++;
        if (m_run[i] == DB) begin
          m_s[i]   = ~m_s[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_s_old = s_prev;
    m_pipe2 = m_pipe1;
    m_pipe1 = raw;
  endtask

  initial begin
    logic [2:0] raw;
    logic       rst_seen;
    model_reset();
    forever begin
      @(posedge clk_c);
      ncyc++;
      raw      = {en_raw_c, down_raw_c, up_raw_c};
      rst_seen = reset_c;
      #1;
      if (rst_seen) model_reset();
      else model_step(raw, ncyc);
      check($sformatf("up_p@%0d", ncyc),         up_p_c,   m_p[0]);
      check($sformatf("down_p@%0d", ncyc),       down_p_c, m_p[1]);
      check($sformatf("enable@%0d", ncyc),       enable_c, m_s[2]);
      check($sformatf("up_p_norpt@%0d", ncyc),   up_p_n,   m_pn[0]);
      check($sformatf("down_p_norpt@%0d", ncyc), down_p_n, m_pn[1]);
      check($sformatf("enable_norpt@%0d", ncyc), enable_n, m_s[2]);
      check($sformatf("overlap@%0d", ncyc),      up_p_c & down_p_c, 1'b0);
      if (up_p_c)   up_log.push_back(ncyc);
      if (down_p_c) dn_log.push_back(ncyc);
      if (up_p_n)   up_log_n.push_back(ncyc);
      if (down_p_n) dn_log_n.push_back(ncyc);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk_c);
  endtask

  task automatic wait_edge(input int target);
    int guard;
    guard = 0;
    while (ncyc < target && guard < 500) begin
      @(negedge clk_c);
      guard++;
    end
    if (ncyc < target) check("wait_edge_timeout", ncyc, target);
  endtask

  task automatic clear_logs();
    up_log.delete(); dn_log.delete(); up_log_n.delete(); dn_log_n.delete();
  endtask

  task automatic check_log(input string name, input int got[$], input int exp[$]);
    check({name, "_count"}, got.size(), exp.size());
    for (int i = 0; i < got.size() && i < exp.size(); i++)
      check($sformatf("%s[%0d]", name, i), got[i], exp[i]);
  endtask

  initial begin
    int t;
    int td;
    int exp_q[$];
    int none_q[$];
    rpt_offs = '{0, 20, 28, 36, 44, 52};
    none_q.delete();

    reset_c = 1'b1;
    idle(2);
    check("reset_up_p", up_p_c, 1'b0);
    check("reset_down_p", down_p_c, 1'b0);
    check("reset_enable", enable_c, 1'b0);
    reset_c = 1'b0;
    idle(3);

    // Enable: 3-clock glitch is ignored, steady level accepted after DB+2 edges.
    en_raw_c = 1'b1;
    idle(3);
    en_raw_c = 1'b0;
    idle(10);
    check("glitch_enable", enable_c, 1'b0);
    en_raw_c = 1'b1;
    t = ncyc + 1;
    wait_edge(t + 4);
    check("enable_not_yet", enable_c, 1'b0);
    wait_edge(t + 5);
    check("enable_settled", enable_c, 1'b1);
    check("enable_settled_norpt", enable_n, 1'b1);

    // Bounce: toggles every 2 clocks, then a clean hold gives one pulse 6 edges on.
    clear_logs();
    for (int i = 0; i < 10; i++) begin
      up_raw_c = ~up_raw_c;
      idle(2);
    end
    up_raw_c = 1'b1;
    t = ncyc + 1;
    idle(16);
    up_raw_c = 1'b0;
    idle(10);
    exp_q.delete(); exp_q.push_back(t + 6);
    check_log("bounce_up", up_log, exp_q);
    check_log("bounce_up_norpt", up_log_n, exp_q);
    check_log("bounce_down", dn_log, none_q);

    // Auto-repeat: down held 60 clocks.
    clear_logs();
    down_raw_c = 1'b1;
    t = ncyc + 1;
    idle(60);
    down_raw_c = 1'b0;
    idle(12);
    exp_q.delete();
    for (int i = 0; i < 6; i++) exp_q.push_back(t + 6 + rpt_offs[i]);
    check_log("repeat_down", dn_log, exp_q);
    exp_q.delete(); exp_q.push_back(t + 6);
    check_log("single_down_norpt", dn_log_n, exp_q);
    check_log("repeat_up", up_log, none_q);

    // Conflict: up held, down joins 10 clocks later.
    clear_logs();
    up_raw_c = 1'b1;
    t = ncyc + 1;
    idle(10);
    down_raw_c = 1'b1;
    idle(30);
    exp_q.delete(); exp_q.push_back(t + 6);
    check_log("conflict_up", up_log, exp_q);
    check_log("conflict_down", dn_log, none_q);
    up_raw_c = 1'b0;
    idle(20);
    check_log("conflict_down_after_up_release", dn_log, none_q);
    down_raw_c = 1'b0;
    idle(10);
    down_raw_c = 1'b1;
    td = ncyc + 1;
    idle(12);
    down_raw_c = 1'b0;
    idle(10);
    exp_q.delete(); exp_q.push_back(td + 6);
    check_log("repress_down", dn_log, exp_q);

    // Both pressed on the same clock: nothing at all.
    clear_logs();
    up_raw_c   = 1'b1;
    down_raw_c = 1'b1;
    idle(30);
    up_raw_c   = 1'b0;
    down_raw_c = 1'b0;
    idle(10);
    check_log("simul_up", up_log, none_q);
    check_log("simul_down", dn_log, none_q);

    // Reset mid-press: outputs clear at once, held button re-presses after release.
    clear_logs();
    up_raw_c = 1'b1;
    t = ncyc + 1;
    wait_edge(t + 6);
    check("pre_reset_up_p", up_p_c, 1'b1);
    check("pre_reset_enable", enable_c, 1'b1);
    reset_c = 1'b1;
    #1;
    check("async_reset_up_p", up_p_c, 1'b0);
    check("async_reset_enable", enable_c, 1'b0);
    check("async_reset_up_p_norpt", up_p_n, 1'b0);
    check("async_reset_enable_norpt", enable_n, 1'b0);
    @(negedge clk_c);
    reset_c = 1'b0;
    clear_logs();
    t = ncyc + 1;
    idle(16);
    up_raw_c = 1'b0;
    idle(10);
    exp_q.delete(); exp_q.push_back(t + 6);
    check_log("post_reset_up", up_log, exp_q);
    check_log("post_reset_up_norpt", up_log_n, exp_q);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
